// File: rtl/ct_spsram_pipe_wrap.sv
// ct_spsram_pipe_wrap: single-port SRAM wrapper with valid/ready request and response channels.
// Optional CT_SPSRAM_INIT_EN: zero-fill sweep of the whole array after reset before accepting requests.
module ct_spsram_pipe_wrap #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LAT     = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done
);

   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam int RSP_DEPTH = RD_LAT + 1;
   localparam int CW        = $clog2(RSP_DEPTH + 1);
   localparam int PW        = $clog2(RSP_DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic                  cen;
   logic                  gwen;
   logic [DATA_WIDTH-1:0] wen;
   logic                  rd_fire;

   logic                  arr_we;
   logic [ADDR_WIDTH-1:0] arr_addr;
   logic [DATA_WIDTH-1:0] arr_wdata;
   logic [DATA_WIDTH-1:0] arr_wen;

   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  pop;

   logic [CW-1:0]         cnt;
   logic [CW-1:0]         occ;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];

   assign accept  = req_vld & req_rdy;
   assign cen     = ~accept;
   assign gwen    = ~req_wr;
   assign wen     = ~req_wmask;
   assign rd_fire = ~cen & gwen;

`ifdef CT_SPSRAM_INIT_EN
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] init_addr;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q   <= ST_INIT;
         init_addr <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) init_addr <= init_addr + 1'b1;
      end
   end

   // The sweep owns the array port while in INIT; requests cannot be accepted then.
   always_comb begin
      state_d   = state_q;
      arr_we    = ~cen & ~gwen;
      arr_addr  = req_addr;
      arr_wdata = req_wdata;
      arr_wen   = wen;
      if (state_q == ST_INIT) begin
         arr_we    = 1'b1;
         arr_addr  = init_addr;
         arr_wdata = '0;
         arr_wen   = '0;
         if (init_addr == '1) state_d = ST_RUN;
      end
   end

   assign init_done = (state_q == ST_RUN);
`else
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) init_done <= 1'b0;
      else           init_done <= 1'b1;
   end

   assign arr_we    = ~cen & ~gwen;
   assign arr_addr  = req_addr;
   assign arr_wdata = req_wdata;
   assign arr_wen   = wen;
`endif

   // Array contents deliberately survive reset.
   always_ff @(posedge forever_cpuclk) begin
      if (arr_we) mem[arr_addr] <= (mem[arr_addr] & arr_wen) | (arr_wdata & ~arr_wen);
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic                  stage_vld;
         logic [DATA_WIDTH-1:0] stage_data;

         always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
               stage_vld  <= 1'b0;
               stage_data <= '0;
            end else begin
               stage_vld <= rd_fire;
               if (rd_fire) stage_data <= mem[req_addr];
            end
         end

         assign push      = stage_vld;
         assign push_data = stage_data;
      end else begin : g_lat1
         assign push      = rd_fire;
         assign push_data = mem[req_addr];
      end
   endgenerate

   assign pop       = rsp_vld & rsp_rdy;
   assign rsp_vld   = (occ != '0);
   assign rsp_rdata = fifo[rd_ptr];
   assign req_rdy   = init_done & (cnt < CW'(RSP_DEPTH));

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cnt    <= '0;
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
      end else begin
         case ({rd_fire, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         if (push) begin
            fifo[wr_ptr] <= push_data;
            wr_ptr       <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
      end
   end

endmodule
